// File: rtl/pilha_param.sv
`default_nettype none
// ============================================================================
// Module      : pilha_param
// Description : Parametrised LIFO stack with combinational top-of-stack view,
//               push+pop replace/bypass, synchronous clear, occupancy count,
//               pop-valid strobe and sticky overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module pilha_param #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic             err_clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);

    localparam int          c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] c_ONE   = CW'(1);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_vld;
    logic             r_ovf;
    logic             r_unf;

    logic             w_empty;
    logic             w_full;
    logic [CW-1:0]    w_top_ptr;
    logic [c_AW-1:0]  w_rd_idx;
    logic [CW-1:0]    w_wr_ptr;
    logic [c_AW-1:0]  w_wr_idx;
    logic             w_wr_en;
    logic             w_act_clear;
    logic             w_act_repl;
    logic             w_act_push;
    logic             w_act_pop;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic [WIDTH-1:0] w_top_data;

    // Occupancy decode
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_DEPTH);
    assign w_top_ptr = r_count - c_ONE;
    assign w_rd_idx  = c_AW'(w_top_ptr);

    // One action per cycle, clear has the highest priority
    assign w_act_clear = clear;
    assign w_act_repl  = !clear &&  push &&  pop;
    assign w_act_push  = !clear &&  push && !pop;
    assign w_act_pop   = !clear && !push &&  pop;

    // Errors are only raised by the single-sided operations
    assign w_ovf_set = w_act_push && w_full;
    assign w_unf_set = w_act_pop  && w_empty;

    // Push writes above the top; replace overwrites the top in place
    assign w_wr_en  = !rst && ((w_act_push && !w_full) || (w_act_repl && !w_empty));
    assign w_wr_ptr = w_act_push ? r_count : w_top_ptr;
    assign w_wr_idx = c_AW'(w_wr_ptr);

    assign w_top_data = r_mem[w_rd_idx];
    assign top        = w_empty ? '0 : w_top_data;

    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;
    assign count    = r_count;
    assign empty    = w_empty;
    assign full     = w_full;
    assign ovf      = r_ovf;
    assign unf      = r_unf;

    // Storage array: written only on accepted push/replace, never reset
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= din;
        end
    end

    // Control state: count, popped data, strobe and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            r_dout_vld <= 1'b0;
            if (w_act_clear) begin
                r_count <= '0;
                r_dout  <= '0;
            end else if (w_act_repl) begin
                // Empty stack: the pushed word passes straight through
                r_dout     <= w_empty ? din : w_top_data;
                r_dout_vld <= 1'b1;
            end else if (w_act_push) begin
                if (!w_full) begin
                    r_count <= r_count + c_ONE;
                end
            end else if (w_act_pop) begin
                if (!w_empty) begin
                    r_dout     <= w_top_data;
                    r_count    <= w_top_ptr;
                    r_dout_vld <= 1'b1;
                end
            end
            // A new error in the same cycle as err_clr keeps the flag set
            r_ovf <= w_ovf_set || (r_ovf && !err_clr);
            r_unf <= w_unf_set || (r_unf && !err_clr);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pilha_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_pilha_param
// Description : Self-checking bench for pilha_param: directed scenarios plus
//               randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pilha_param;

    localparam int c_WIDTH = 8;
    localparam int c_DEPTH = 8;
    localparam int c_CW    = 4;

    logic               clk;
    logic               rst;
    logic               push;
    logic               pop;
    logic               clear;
    logic               err_clr;
    logic [c_WIDTH-1:0] din;
    logic [c_WIDTH-1:0] dout;
    logic               dout_vld;
    logic [c_WIDTH-1:0] top;
    logic [c_CW-1:0]    count;
    logic               empty;
    logic               full;
    logic               ovf;
    logic               unf;

    int n_checks;
    int n_fail;

    // Reference model state
    logic [c_WIDTH-1:0] m_stack[$];
    logic [c_WIDTH-1:0] m_dout;
    logic               m_vld;
    logic               m_ovf;
    logic               m_unf;

    pilha_param #(
        .WIDTH (c_WIDTH),
        .DEPTH (c_DEPTH),
        .CW    (c_CW)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .clear    (clear),
        .err_clr  (err_clr),
        .din      (din),
        .dout     (dout),
        .dout_vld (dout_vld),
        .top      (top),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .ovf      (ovf),
        .unf      (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural stack update for one clock edge
    task automatic model_step(input logic r, input logic pu, input logic po,
                              input logic cl, input logic ec, input logic [c_WIDTH-1:0] d);
        logic so;
        logic su;
        so = 1'b0;
        su = 1'b0;
        if (r) begin
            m_stack.delete();
            m_dout = '0;
            m_vld  = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            m_vld = 1'b0;
            if (cl) begin
                m_stack.delete();
                m_dout = '0;
            end else if (pu && po) begin
                if (m_stack.size() > 0) begin
                    m_dout = m_stack[$];
                    m_stack[m_stack.size()-1] = d;
                end else begin
                    m_dout = d;
                end
                m_vld = 1'b1;
            end else if (pu) begin
                if (m_stack.size() < c_DEPTH) m_stack.push_back(d);
                else so = 1'b1;
            end else if (po) begin
                if (m_stack.size() > 0) begin
                    m_dout = m_stack.pop_back();
                    m_vld  = 1'b1;
                end else begin
                    su = 1'b1;
                end
            end
            m_ovf = so || (m_ovf && !ec);
            m_unf = su || (m_unf && !ec);
        end
    endtask

    task automatic compare_all();
        logic [c_WIDTH-1:0] e_top;
        e_top = (m_stack.size() > 0) ? m_stack[$] : '0;
        chk("dout",     32'(dout),     32'(m_dout));
        chk("dout_vld", 32'(dout_vld), 32'(m_vld));
        chk("top",      32'(top),      32'(e_top));
        chk("count",    32'(count),    32'(m_stack.size()));
        chk("empty",    32'(empty),    32'(m_stack.size() == 0));
        chk("full",     32'(full),     32'(m_stack.size() == c_DEPTH));
        chk("ovf",      32'(ovf),      32'(m_ovf));
        chk("unf",      32'(unf),      32'(m_unf));
    endtask

    // Drive one cycle, advance the model, then check 1ns after the edge
    task automatic cyc(input logic r, input logic pu, input logic po,
                       input logic cl, input logic ec, input logic [c_WIDTH-1:0] d);
        rst     = r;
        push    = pu;
        pop     = po;
        clear   = cl;
        err_clr = ec;
        din     = d;
        @(posedge clk);
        model_step(r, pu, po, cl, ec, d);
        #1;
        compare_all();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_dout   = '0;
        m_vld    = 1'b0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        rst = 1'b1; push = 1'b0; pop = 1'b0; clear = 1'b0; err_clr = 1'b0; din = '0;

        // Reset then idle
        cyc(1, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 8'h00);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);

        // Fill to full, then one push too many
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 0, 0, 0, 8'(8'h10 + i));
            chk("fill_count", 32'(count), 32'(i + 1));
        end
        chk("fill_top",  32'(top),  32'h17);
        chk("fill_full", 32'(full), 32'd1);
        cyc(0, 1, 0, 0, 0, 8'hAA);
        chk("ovf_set",  32'(ovf),   32'd1);
        chk("ovf_top",  32'(top),   32'h17);
        chk("ovf_cnt",  32'(count), 32'd8);

        // Drain completely, then one pop too many
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 0, 0, 8'h00);
            chk("drain_dout", 32'(dout), 32'(8'h17 - i));
            chk("drain_vld",  32'(dout_vld), 32'd1);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        cyc(0, 0, 1, 0, 0, 8'h00);
        chk("unf_set",  32'(unf),      32'd1);
        chk("unf_dout", 32'(dout),     32'h10);
        chk("unf_vld",  32'(dout_vld), 32'd0);

        // Replace on non-empty, bypass on empty
        cyc(0, 0, 0, 0, 1, 8'h00);
        cyc(0, 1, 0, 0, 0, 8'h01);
        cyc(0, 1, 0, 0, 0, 8'h02);
        cyc(0, 1, 1, 0, 0, 8'h55);
        chk("repl_dout", 32'(dout),  32'h02);
        chk("repl_top",  32'(top),   32'h55);
        chk("repl_cnt",  32'(count), 32'd2);
        cyc(0, 0, 0, 1, 0, 8'h00);
        cyc(0, 1, 1, 0, 0, 8'h33);
        chk("byp_dout", 32'(dout),     32'h33);
        chk("byp_vld",  32'(dout_vld), 32'd1);
        chk("byp_cnt",  32'(count),    32'd0);

        // Error clear racing a new overflow, then clear with a pending push
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 0, 8'(8'h40 + i));
        cyc(0, 1, 0, 0, 0, 8'hEE);
        cyc(0, 1, 0, 0, 1, 8'hEF);
        chk("errclr_race", 32'(ovf), 32'd1);
        cyc(0, 0, 0, 0, 1, 8'h00);
        chk("errclr_only", 32'(ovf), 32'd0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 8'h00);
        chk("pre_clr_cnt", 32'(count), 32'd5);
        cyc(0, 1, 0, 1, 0, 8'h99);
        chk("clr_cnt",  32'(count), 32'd0);
        chk("clr_dout", 32'(dout),  32'd0);
        chk("clr_ovf",  32'(ovf),   32'd0);

        // Reset overriding a pop mid-sequence
        cyc(0, 1, 0, 0, 0, 8'h21);
        cyc(0, 1, 0, 0, 0, 8'h22);
        cyc(0, 1, 0, 0, 0, 8'h23);
        cyc(1, 0, 1, 0, 0, 8'h00);
        chk("rstpop_cnt", 32'(count),    32'd0);
        chk("rstpop_vld", 32'(dout_vld), 32'd0);
        chk("rstpop_unf", 32'(unf),      32'd0);

        // Randomized traffic with a drifting push bias to visit full and empty
        begin
            int push_pct;
            push_pct = 50;
            for (int i = 0; i < 3000; i++) begin
                logic r, pu, po, cl, ec;
                if ((i % 64) == 0) push_pct = int'($urandom_range(15, 85));
                r  = ($urandom_range(0, 199) == 0);
                cl = ($urandom_range(0, 39) == 0);
                ec = ($urandom_range(0, 11) == 0);
                pu = ($urandom_range(0, 99) < push_pct);
                po = ($urandom_range(0, 99) < (100 - push_pct));
                cyc(r, pu, po, cl, ec, 8'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
